// File: rtl/bus_dmem_responder_if.sv
// Load/store bus between the CPU datapath (master) and the data-memory responder (slave).
interface bus_dmem_responder_if;
   logic        busSel;
   logic        busWe;
   logic [31:0] busAddr;
   logic [31:0] busWData;
   logic [2:0]  busFunc3;
   logic [31:0] busRData;
   logic        busReady;
   logic        busErr;

   modport master (
      output busSel, busWe, busAddr, busWData, busFunc3,
      input  busRData, busReady, busErr
   );

   modport slave (
      input  busSel, busWe, busAddr, busWData, busFunc3,
      output busRData, busReady, busErr
   );
endinterface

// File: rtl/bus_dmem_responder.sv
// Data-memory responder: one load/store at a time, B/H/W little-endian accesses,
// programmable wait states, single-cycle ready/err response from an internal word RAM.
module bus_dmem_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          WAIT_STATES = 1
) (
   input logic                 clk,
   input logic                 reset,
   bus_dmem_responder_if.slave bus
);
   localparam int          IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
   localparam logic [4:0]  CNT_LOAD = 5'(WAIT_STATES + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             we_q;
   logic [2:0]       func3_q;
   logic [31:0]      wdata_q;
   logic [IDX_W-1:0] idx_q;
   logic [1:0]       lane_q;
   logic             err_q;
   logic [31:0]      rdata_q;

   logic [31:0]      req_offset;
   logic             req_err;
   logic             accept;
   logic             commit;
   logic [IDX_W-1:0] rd_idx;
   logic [31:0]      rd_word_q;
   logic [3:0]       be;
   logic [31:0]      wlanes;
   logic [31:0]      shifted;
   logic [31:0]      load_val;

   logic [3:0][7:0]  mem [DEPTH_WORDS];

   assign req_offset = bus.busAddr - BASE_ADDR;

   // All error rules are evaluated once, on the live bus, at acceptance.
   always_comb begin
      req_err = (req_offset >= SPAN);
      case (bus.busFunc3)
         3'b000, 3'b100: ;
         3'b001, 3'b101: if (bus.busAddr[0]) req_err = 1'b1;
         3'b010:         if (bus.busAddr[1:0] != 2'b00) req_err = 1'b1;
         default:        req_err = 1'b1;
      endcase
      if (bus.busWe && bus.busFunc3[2]) req_err = 1'b1;
   end

   assign accept = (state_q == IDLE) && bus.busSel;
   assign commit = (state_q == WAIT) && (cnt_q == 5'd1);

   // Counter is loaded with WAIT_STATES+1 so the commit edge always follows acceptance by WAIT_STATES+1 edges.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.busSel) begin
               state_d = WAIT;
               cnt_d   = CNT_LOAD;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         we_q    <= 1'b0;
         func3_q <= 3'd0;
         wdata_q <= 32'd0;
         idx_q   <= '0;
         lane_q  <= 2'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= bus.busWe;
            func3_q <= bus.busFunc3;
            wdata_q <= bus.busWData;
            idx_q   <= req_offset[IDX_W+1:2];
            lane_q  <= req_offset[1:0];
            err_q   <= req_err;
         end
         if (commit && !we_q) rdata_q <= err_q ? 32'd0 : load_val;
      end
   end

   // Read address follows the live bus while idle so the word is ready even with no wait states.
   assign rd_idx = (state_q == IDLE) ? req_offset[IDX_W+1:2] : idx_q;

   always_ff @(posedge clk) begin
      rd_word_q <= mem[rd_idx];
      if (commit && we_q && !err_q) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx_q][b] <= wlanes[8*b +: 8];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign be[gi] = (func3_q[1:0] == 2'b10)
                      || ((func3_q[1:0] == 2'b01) && (lane_q[1] == LANE[1]))
                      || ((func3_q[1:0] == 2'b00) && (lane_q == LANE));
         assign wlanes[8*gi +: 8] = (func3_q[1:0] == 2'b10) ? wdata_q[8*gi +: 8] :
                                    (func3_q[1:0] == 2'b01) ? wdata_q[8*(gi%2) +: 8] :
                                                              wdata_q[7:0];
      end
   endgenerate

   assign shifted = rd_word_q >> {lane_q, 3'b000};

   always_comb begin
      case (func3_q)
         3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_val = {24'd0, shifted[7:0]};
         3'b101:  load_val = {16'd0, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   assign bus.busReady = (state_q == RESP);
   assign bus.busErr   = (state_q == RESP) && err_q;
   assign bus.busRData = rdata_q;
endmodule

// File: tb/tb_bus_dmem_responder.sv
// Bench for bus_dmem_responder: three instances (0, 1 and 3 wait states) sharing one stimulus bus.
module tb_bus_dmem_responder;
   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam int          DEPTH = 256;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bus_dmem_responder_if bus0 ();
   bus_dmem_responder_if bus1 ();
   bus_dmem_responder_if bus2 ();

   bus_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0))
      dut0 (.clk(clk), .reset(reset), .bus(bus0));
   bus_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(1))
      dut1 (.clk(clk), .reset(reset), .bus(bus1));
   bus_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3))
      dut2 (.clk(clk), .reset(reset), .bus(bus2));

   int          cur;
   logic        sel, we;
   logic [31:0] addr, wdata;
   logic [2:0]  f3;

   assign bus0.busSel = sel && (cur == 0);
   assign bus1.busSel = sel && (cur == 1);
   assign bus2.busSel = sel && (cur == 2);
   assign bus0.busWe = we;    assign bus1.busWe = we;    assign bus2.busWe = we;
   assign bus0.busAddr = addr; assign bus1.busAddr = addr; assign bus2.busAddr = addr;
   assign bus0.busWData = wdata; assign bus1.busWData = wdata; assign bus2.busWData = wdata;
   assign bus0.busFunc3 = f3; assign bus1.busFunc3 = f3; assign bus2.busFunc3 = f3;

   logic        ready, errv;
   logic [31:0] rdata;
   always_comb begin
      case (cur)
         0:       begin ready = bus0.busReady; errv = bus0.busErr; rdata = bus0.busRData; end
         1:       begin ready = bus1.busReady; errv = bus1.busErr; rdata = bus1.busRData; end
         default: begin ready = bus2.busReady; errv = bus2.busErr; rdata = bus2.busRData; end
      endcase
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int ws_of(input int c);
      return (c == 0) ? 0 : (c == 1) ? 1 : 3;
   endfunction

   // Reference model: byte-addressed memory per instance plus the last load result.
   logic [7:0]  mmem [3][DEPTH*4];
   logic [31:0] mlast [3];

   task automatic model_txn(input int c, input logic mwe, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] f, output logic e, output logic [31:0] rd);
      logic [31:0] off, v, mask;
      int size;
      off  = a - BASE;
      size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
      e = (off >= 32'(DEPTH*4)) || (f == 3'd3) || (f == 3'd6) || (f == 3'd7) || (mwe && f[2])
          || ((size == 2) && a[0]) || ((size == 4) && (a[1:0] != 2'b00));
      if (e) begin
         if (!mwe) mlast[c] = 32'd0;
      end else if (mwe) begin
         for (int i = 0; i < size; i++) mmem[c][int'(off) + i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < size; i++) v = v | (32'(mmem[c][int'(off) + i]) << (8*i));
         if (size < 4) begin
            mask = (32'd1 << (8*size)) - 32'd1;
            if (!f[2] && v[8*size-1]) v = v | ~mask;
         end
         mlast[c] = v;
      end
      rd = mlast[c];
   endtask

   // One bus transaction; sel stays high through the RESP edge, which must not start a new request.
   task automatic txn(input int c, input logic twe, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f, input bit hold,
                      output logic gerr, output logic [31:0] grd, output int lat);
      bit done;
      @(negedge clk);
      cur = c; we = twe; addr = a; wdata = wd; f3 = f; sel = 1'b1;
      @(posedge clk);
      lat = 0; done = 0; gerr = 1'b0; grd = 32'd0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (ready) done = 1;
      end
      gerr = errv;
      grd  = rdata;
      @(posedge clk); #1;
      chk("ready_one_cycle", {31'd0, ready}, 32'd0);
      @(negedge clk);
      sel = 1'b0;
      if (hold) begin
         for (int i = 0; i < ws_of(c) + 3; i++) begin
            @(posedge clk); #1;
            chk("no_restart_from_resp", {31'd0, ready}, 32'd0);
         end
      end
   endtask

   task automatic do_check(input int c, input logic twe, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f, input bit hold, input string name);
      logic e, ge;
      logic [31:0] r, gr;
      int lat;
      model_txn(c, twe, a, wd, f, e, r);
      txn(c, twe, a, wd, f, hold, ge, gr, lat);
      $display("txn %s dut%0d we=%0d addr=%08h wdata=%08h f3=%03b -> rdata=%08h err=%0d lat=%0d",
               name, c, twe, a, wd, f, gr, ge, lat);
      chk({name, "_latency"}, 32'(lat), 32'(ws_of(c) + 1));
      chk({name, "_err"}, {31'd0, ge}, {31'd0, e});
      chk({name, "_rdata"}, gr, r);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [17];

   initial begin
      logic        me, ge, twe;
      logic [31:0] mr, gr, ta, twd;
      logic [2:0]  tf;
      int          lat, c, r;

      vecs[0]  = '{1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b0, 32'h1000_0004, 32'h0,         3'b010, 1'b0, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 32'h1000_0005, 32'h0000_00A5, 3'b000, 1'b0, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b0, 32'h1000_0004, 32'h0,         3'b010, 1'b0, 32'hDEAD_A5EF};
      vecs[4]  = '{1'b0, 32'h1000_0005, 32'h0,         3'b000, 1'b0, 32'hFFFF_FFA5};
      vecs[5]  = '{1'b0, 32'h1000_0005, 32'h0,         3'b100, 1'b0, 32'h0000_00A5};
      vecs[6]  = '{1'b1, 32'h1000_0006, 32'h0000_8001, 3'b001, 1'b0, 32'h0000_00A5};
      vecs[7]  = '{1'b0, 32'h1000_0004, 32'h0,         3'b010, 1'b0, 32'h8001_A5EF};
      vecs[8]  = '{1'b0, 32'h1000_0006, 32'h0,         3'b001, 1'b0, 32'hFFFF_8001};
      vecs[9]  = '{1'b0, 32'h1000_0006, 32'h0,         3'b101, 1'b0, 32'h0000_8001};
      vecs[10] = '{1'b0, 32'h1000_0002, 32'h0,         3'b010, 1'b1, 32'h0000_0000};
      vecs[11] = '{1'b1, 32'h1000_0001, 32'h0000_FFFF, 3'b001, 1'b1, 32'h0000_0000};
      vecs[12] = '{1'b0, 32'h0FFF_FFFC, 32'h0,         3'b010, 1'b1, 32'h0000_0000};
      vecs[13] = '{1'b0, 32'h1000_0004, 32'h0,         3'b011, 1'b1, 32'h0000_0000};
      vecs[14] = '{1'b0, 32'h1000_0004, 32'h0,         3'b010, 1'b0, 32'h8001_A5EF};
      vecs[15] = '{1'b1, 32'h1000_0004, 32'h1111_2222, 3'b100, 1'b1, 32'h8001_A5EF};
      vecs[16] = '{1'b0, 32'h1000_0004, 32'h0,         3'b010, 1'b0, 32'h8001_A5EF};

      for (int k = 0; k < 3; k++) begin
         mlast[k] = 32'd0;
         for (int i = 0; i < DEPTH*4; i++) mmem[k][i] = 8'd0;
      end

      cur = 0; sel = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; f3 = 3'd0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready0", {31'd0, bus0.busReady}, 32'd0);
      chk("reset_ready1", {31'd0, bus1.busReady}, 32'd0);
      chk("reset_ready2", {31'd0, bus2.busReady}, 32'd0);
      chk("reset_err1",   {31'd0, bus1.busErr},   32'd0);
      chk("reset_rdata0", bus0.busRData, 32'd0);
      chk("reset_rdata1", bus1.busRData, 32'd0);
      chk("reset_rdata2", bus2.busRData, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Known contents for the test window in every instance.
      for (int k = 0; k < 3; k++)
         for (int w = 0; w < 16; w++)
            do_check(k, 1'b1, BASE + 32'(4*w), 32'd0, 3'b010, 1'b0, "clear");

      for (int i = 0; i < 17; i++) begin
         model_txn(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, me, mr);
         txn(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, 1'b0, ge, gr, lat);
         $display("txn vec%0d we=%0d addr=%08h f3=%03b -> rdata=%08h err=%0d lat=%0d",
                  i, vecs[i].we, vecs[i].addr, vecs[i].f3, gr, ge, lat);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
         chk($sformatf("vec%0d_err", i), {31'd0, ge}, {31'd0, vecs[i].exp_err});
         chk($sformatf("vec%0d_rdata", i), gr, vecs[i].exp_rdata);
      end

      // Zero and three wait states, sel held through RESP.
      do_check(0, 1'b1, BASE + 32'h8, 32'h0BAD_F00D, 3'b010, 1'b1, "w0_sw");
      do_check(0, 1'b0, BASE + 32'h8, 32'd0,         3'b010, 1'b1, "w0_lw");
      do_check(2, 1'b1, BASE + 32'h8, 32'h7654_3210, 3'b010, 1'b1, "w3_sw");
      do_check(2, 1'b0, BASE + 32'h9, 32'd0,         3'b000, 1'b1, "w3_lb");

      // Reset in the middle of a store's wait period.
      do_check(2, 1'b1, BASE + 32'h10, 32'hCAFE_F00D, 3'b010, 1'b0, "rst_pre_sw");
      do_check(2, 1'b0, BASE + 32'h10, 32'd0,         3'b010, 1'b0, "rst_pre_lw");
      @(negedge clk);
      cur = 2; we = 1'b1; addr = BASE + 32'h10; wdata = 32'h1234_5678; f3 = 3'b010; sel = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sel = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_async_rdata", bus2.busRData, 32'd0);
      chk("rst_async_ready", {31'd0, bus2.busReady}, 32'd0);
      chk("rst_async_err",   {31'd0, bus2.busErr},   32'd0);
      for (int k = 0; k < 3; k++) mlast[k] = 32'd0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("rst_no_ready", {31'd0, bus2.busReady}, 32'd0);
      end
      do_check(2, 1'b0, BASE + 32'h10, 32'd0, 3'b010, 1'b0, "rst_post_lw");

      // Randomized traffic against the model.
      for (int n = 0; n < 200; n++) begin
         c   = $urandom_range(0, 2);
         twe = 1'($urandom_range(0, 1));
         twd = $urandom;
         r   = $urandom_range(0, 19);
         if (r == 0)      ta = BASE - 32'(4 * $urandom_range(1, 4));
         else if (r == 1) ta = BASE + 32'(DEPTH*4) + 32'($urandom_range(0, 63));
         else             ta = BASE + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) < 8) begin
            r  = $urandom_range(0, 4);
            tf = (r == 0) ? 3'b000 : (r == 1) ? 3'b001 : (r == 2) ? 3'b010 : (r == 3) ? 3'b100 : 3'b101;
         end else begin
            tf = 3'($urandom_range(0, 7));
         end
         do_check(c, twe, ta, twd, tf, 1'b0, "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
